mmio_write_ctrl: RTL and testbench

MMIO_WRITE_CTRL -- requirements
Module: mmio_write_ctrl

---
 rtl/mmio_write_ctrl.sv | 81 ++++++++
 tb/tb_mmio_write_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_write_ctrl.sv
// mmio_write_ctrl: routes LSU stores to DCCM, a console byte FIFO, or an end-of-test latch
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   lsu_wen/lsu_waddr/lsu_wdata       store request from the LSU
//   lsu_stall                         store held off (console FIFO full)
//   dccm_wen/dccm_waddr/dccm_wdata    plain stores forwarded with zero latency
//   con_valid/con_data/con_ready      console byte stream out of the FIFO
//   con_count                         FIFO occupancy
//   finish/finish_code                sticky end-of-test flag and its code byte
//   drop_cnt                          saturating count of stores dropped after the finish store
module mmio_write_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] CONSOLE_ADDR = 32'h0020_0000,
  parameter logic [XLEN-1:0] FINISH_ADDR = 32'h1000_0000,
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_wen,
  input  logic [XLEN-1:0] lsu_waddr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_stall,
  output logic            dccm_wen,
  output logic [XLEN-1:0] dccm_waddr,
  output logic [XLEN-1:0] dccm_wdata,
  output logic            con_valid,
  output logic [7:0]      con_data,
  input  logic            con_ready,
  output logic [CW-1:0]   con_count,
  output logic            finish,
  output logic [7:0]      finish_code,
  output logic [15:0]     drop_cnt
);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic is_con, is_fin, run, full, push, pop, drop, fin_req;
  assign is_con = lsu_waddr == CONSOLE_ADDR;
  assign is_fin = lsu_waddr == FINISH_ADDR;
  assign full = con_count == CW'(FIFO_DEPTH);
  assign con_valid = con_count != '0;
  assign con_data = mem[rd_ptr];
  assign pop = con_valid & con_ready;
  assign dccm_waddr = lsu_waddr;
  assign dccm_wdata = lsu_wdata;
  // rst_n gates the combinational outputs so nothing leaks out while reset is held
  always_comb begin
    run = state == RUN;
    fin_req = run & lsu_wen & is_fin;
    lsu_stall = rst_n & run & lsu_wen & is_con & full;
    push = run & lsu_wen & is_con & ~full;
    dccm_wen = rst_n & run & lsu_wen & ~is_con & ~is_fin;
    drop = ~run & lsu_wen;
    state_nxt = fin_req ? DRAIN : (state == DRAIN && con_count == '0) ? DONE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      con_count <= '0;
      finish <= 1'b0;
      finish_code <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      con_count <= con_count + CW'(push) - CW'(pop);
      finish <= finish | (state == DONE);
      if (fin_req) finish_code <= lsu_wdata[7:0];
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= lsu_wdata[7:0];
  end
endmodule

// File: tb/tb_mmio_write_ctrl.sv
// tb_mmio_write_ctrl: directed stimulus with a queue-based reference model checked every cycle
module tb_mmio_write_ctrl;
  localparam logic [31:0] CON = 32'h0020_0000;
  localparam logic [31:0] FIN = 32'h1000_0000;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst_n, lsu_wen, lsu_stall, dccm_wen, con_valid, con_ready, finish;
  logic [31:0] lsu_waddr, lsu_wdata, dccm_waddr, dccm_wdata;
  logic [7:0] con_data, finish_code;
  logic [3:0] con_count;
  logic [15:0] drop_cnt;
  int errors = 0;
  int checks = 0;
  byte unsigned q[$];
  int ph = 0;
  bit mfin = 0;
  logic [7:0] mcode = 0;
  int mdrop = 0;
  mmio_write_ctrl dut (
    .clk(clk), .rst_n(rst_n), .lsu_wen(lsu_wen), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .lsu_stall(lsu_stall), .dccm_wen(dccm_wen), .dccm_waddr(dccm_waddr), .dccm_wdata(dccm_wdata),
    .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready), .con_count(con_count),
    .finish(finish), .finish_code(finish_code), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // ph: 0 = accepting stores, 1 = finish seen and waiting for console to empty, 2 = finished
  always @(negedge clk) begin
    bit con, fin, plain;
    int sz, old;
    if (!rst_n) begin
      q.delete();
      ph = 0;
      mfin = 0;
      mcode = 0;
      mdrop = 0;
    end
    con = lsu_waddr == CON;
    fin = lsu_waddr == FIN;
    plain = !con && !fin;
    sz = q.size();
    chk("m_stall", lsu_stall, rst_n && ph == 0 && lsu_wen && con && sz == DEPTH);
    chk("m_dccm_wen", dccm_wen, rst_n && ph == 0 && lsu_wen && plain);
    if (rst_n && ph == 0 && lsu_wen && plain) begin
      chk("m_dccm_waddr", dccm_waddr, lsu_waddr);
      chk("m_dccm_wdata", dccm_wdata, lsu_wdata);
    end
    chk("m_con_valid", con_valid, sz != 0);
    chk("m_con_count", con_count, sz);
    if (sz != 0) chk("m_con_data", con_data, q[0]);
    chk("m_finish", finish, mfin);
    chk("m_finish_code", finish_code, mcode);
    chk("m_drop_cnt", drop_cnt, mdrop);
    if (rst_n) begin
      old = ph;
      if (old == 2) mfin = 1;
      if (old != 0 && lsu_wen) mdrop = mdrop < 65535 ? mdrop + 1 : 65535;
      if (old == 0 && lsu_wen && fin) begin
        mcode = lsu_wdata[7:0];
        ph = 1;
      end else if (old == 1 && sz == 0) ph = 2;
      if (sz != 0 && con_ready) void'(q.pop_front());
      if (old == 0 && lsu_wen && con && sz < DEPTH) q.push_back(lsu_wdata[7:0]);
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    lsu_wen = 0;
    lsu_waddr = 0;
    lsu_wdata = 0;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    lsu_wen = 1;
    lsu_waddr = a;
    lsu_wdata = d;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (!lsu_stall) begin
        cyc();
        idle();
        return;
      end
      cyc();
    end
    chk("store_timeout", 1, 0);
    idle();
  endtask
  initial begin
    rst_n = 0;
    con_ready = 0;
    lsu_wen = 1;
    lsu_waddr = 32'h1000;
    lsu_wdata = 32'h1234;
    #2;
    chk("rst_stall", lsu_stall, 0);
    chk("rst_dccm_wen", dccm_wen, 0);
    chk("rst_con_valid", con_valid, 0);
    chk("rst_con_count", con_count, 0);
    chk("rst_finish", finish, 0);
    chk("rst_drop", drop_cnt, 0);
    repeat (2) cyc();
    idle();
    rst_n = 1;
    cyc();
    lsu_wen = 1;
    lsu_waddr = 32'h0000_1000;
    lsu_wdata = 32'hDEAD_BEEF;
    #1;
    chk("plain_wen", dccm_wen, 1);
    chk("plain_addr", dccm_waddr, 32'h0000_1000);
    chk("plain_data", dccm_wdata, 32'hDEAD_BEEF);
    chk("plain_stall", lsu_stall, 0);
    cyc();
    idle();
    chk("plain_count", con_count, 0);
    con_ready = 1;
    lsu_wen = 1;
    lsu_waddr = CON;
    lsu_wdata = 32'h48;
    #1;
    chk("h_no_bypass", con_valid, 0);
    chk("h_no_dccm", dccm_wen, 0);
    cyc();
    lsu_wdata = 32'h69;
    #1;
    chk("h_valid", con_valid, 1);
    chk("h_data", con_data, 8'h48);
    cyc();
    idle();
    chk("i_data", con_data, 8'h69);
    cyc();
    chk("hi_empty", con_valid, 0);
    con_ready = 0;
    for (int i = 0; i < 8; i++) store(CON, 32'h30 + i);
    chk("full_count", con_count, 8);
    lsu_wen = 1;
    lsu_waddr = CON;
    lsu_wdata = 32'h39;
    #1;
    chk("full_stall", lsu_stall, 1);
    cyc();
    cyc();
    chk("full_stall_hold", lsu_stall, 1);
    con_ready = 1;
    #1;
    chk("stall_no_ready_path", lsu_stall, 1);
    cyc();
    con_ready = 0;
    chk("stall_drop", lsu_stall, 0);
    chk("after_pop_count", con_count, 7);
    cyc();
    idle();
    chk("ninth_pushed", con_count, 8);
    con_ready = 1;
    for (int n = 0; n < 30 && con_valid; n++) cyc();
    chk("drain_empty", con_valid, 0);
    con_ready = 0;
    store(CON, 32'h61);
    store(CON, 32'h62);
    store(CON, 32'h63);
    store(FIN, 32'h0000_002A);
    chk("drain_finish0", finish, 0);
    chk("drain_count", con_count, 3);
    repeat (3) cyc();
    chk("drain_finish_hold", finish, 0);
    con_ready = 1;
    for (int n = 0; n < 20 && !finish; n++) cyc();
    chk("finish_set", finish, 1);
    chk("finish_code", finish_code, 8'h2A);
    chk("finish_count", con_count, 0);
    store(32'h2000, 32'h1);
    store(32'h2004, 32'h2);
    store(CON, 32'h55);
    chk("drop3", drop_cnt, 3);
    chk("drop_no_push", con_count, 0);
    lsu_wen = 1;
    lsu_waddr = 32'h3000;
    repeat (65535) cyc();
    idle();
    chk("drop_sat", drop_cnt, 16'hFFFF);
    cyc();
    chk("finish_sticky", finish, 1);
    rst_n = 0;
    #1;
    chk("rst2_finish", finish, 0);
    chk("rst2_drop", drop_cnt, 0);
    cyc();
    rst_n = 1;
    cyc();
    con_ready = 0;
    for (int i = 0; i < 5; i++) store(CON, 32'h70 + i);
    store(FIN, 32'h7);
    cyc();
    chk("mid_count", con_count, 5);
    chk("mid_finish", finish, 0);
    rst_n = 0;
    #1;
    chk("async_valid", con_valid, 0);
    chk("async_count", con_count, 0);
    chk("async_finish", finish, 0);
    chk("async_code", finish_code, 0);
    cyc();
    rst_n = 1;
    lsu_wen = 1;
    lsu_waddr = 32'h4000;
    lsu_wdata = 32'hCAFE_F00D;
    #1;
    chk("post_rst_wen", dccm_wen, 1);
    chk("post_rst_data", dccm_wdata, 32'hCAFE_F00D);
    cyc();
    idle();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
